// File: rtl/triangle_meas_pkg.sv
// Shared types and default dimensions for the triangle waveform measurement block.
package triangle_meas_pkg;

    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_t;

    localparam int unsigned DT_W_DEF     = 8;
    localparam int unsigned CNT_W_DEF    = 24;
    localparam int unsigned HYST_DEF     = 4;
    localparam int unsigned PERIOD_W_DEF = CNT_W_DEF + 1;

    // period carries one extra bit so rise_len + fall_len never truncates
    function automatic int unsigned period_w(input int unsigned cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/extremum_tracker.sv
// Running extremum (max or min, selected per cycle) with position capture and
// hysteresis turn detection.
module extremum_tracker
    import triangle_meas_pkg::*;
#(
    parameter int unsigned DT_W  = DT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned HYST  = HYST_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic             is_max,
    input  logic             load,
    input  logic [DT_W-1:0]  sample,
    input  logic [CNT_W-1:0] load_pos,
    input  logic [CNT_W-1:0] cur_off,
    output logic [DT_W-1:0]  ext,
    output logic [CNT_W-1:0] ext_pos,
    output logic             turn_c
);

    localparam int unsigned CMP_W = DT_W + 1;

    logic [CMP_W-1:0] retreat;
    logic             better;

    // One extra bit: a negative retreat shows up as a set MSB instead of wrapping
    always_comb begin
        retreat = is_max ? ({1'b0, ext} - {1'b0, sample})
                         : ({1'b0, sample} - {1'b0, ext});
        turn_c  = !retreat[CMP_W-1] && (retreat >= CMP_W'(HYST));
        better  = is_max ? (sample > ext) : (sample < ext);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext     <= '0;
            ext_pos <= '0;
        end else if (accept) begin
            if (load) begin
                ext     <= sample;
                ext_pos <= load_pos;
            end else if (better) begin
                ext     <= sample;
                ext_pos <= cur_off;
            end
        end
    end

endmodule

// File: rtl/triangle_meas.sv
// Triangle waveform measurement: peak, trough, rise/fall length and period per
// completed rise+fall cycle, with hysteresis-based turning point detection.
module triangle_meas
    import triangle_meas_pkg::*;
#(
    parameter int unsigned DT_W  = DT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned HYST  = HYST_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic [DT_W-1:0]            sample,
    output logic                       meas_valid,
    output logic [DT_W-1:0]            peak,
    output logic [DT_W-1:0]            trough,
    output logic [CNT_W-1:0]           rise_len,
    output logic [CNT_W-1:0]           fall_len,
    output logic [period_w(CNT_W)-1:0] period,
    output logic                       timeout
);

    localparam int unsigned PER_W = period_w(CNT_W);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   offset_q, offset_d;
    logic               seeded_q, seeded_d;
    logic               full_rise_q, full_rise_d;
    logic               pk_ok_q, pk_ok_d;
    logic [DT_W-1:0]    pk_q, pk_d;
    logic [CNT_W-1:0]   rl_q, rl_d;

    logic               meas_valid_d, timeout_d;
    logic [DT_W-1:0]    peak_d, trough_d;
    logic [CNT_W-1:0]   rise_len_d, fall_len_d;
    logic [PER_W-1:0]   period_d;

    logic [CNT_W-1:0]   cur_off, rebase, load_pos, ext_pos;
    logic [DT_W-1:0]    ext;
    logic               sat, load, is_max, turn_c;

    extremum_tracker #(
        .DT_W  (DT_W),
        .CNT_W (CNT_W),
        .HYST  (HYST)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (sample_valid),
        .is_max   (is_max),
        .load     (load),
        .sample   (sample),
        .load_pos (load_pos),
        .cur_off  (cur_off),
        .ext      (ext),
        .ext_pos  (ext_pos),
        .turn_c   (turn_c)
    );

    // Next-state, counter and result logic; only accepted samples advance anything
    always_comb begin
        cur_off      = offset_q + CNT_W'(1);
        sat          = (cur_off == {CNT_W{1'b1}});
        rebase       = cur_off - ext_pos;
        is_max       = (state_q == RISE);

        state_d      = state_q;
        offset_d     = offset_q;
        seeded_d     = seeded_q;
        full_rise_d  = full_rise_q;
        pk_ok_d      = pk_ok_q;
        pk_d         = pk_q;
        rl_d         = rl_q;
        load         = 1'b0;
        load_pos     = '0;
        meas_valid_d = 1'b0;
        peak_d       = peak;
        trough_d     = trough;
        rise_len_d   = rise_len;
        fall_len_d   = fall_len;
        period_d     = period;
        timeout_d    = timeout;

        if (sample_valid) begin
            offset_d = cur_off;
            case (state_q)
                ACQ: begin
                    if (!seeded_q) begin
                        seeded_d = 1'b1;
                        load     = 1'b1;
                    end else if (turn_c) begin
                        state_d     = RISE;
                        full_rise_d = 1'b0;
                        load        = 1'b1;
                        offset_d    = '0;
                    end
                end
                RISE: begin
                    if (turn_c) begin
                        pk_d     = ext;
                        rl_d     = ext_pos;
                        pk_ok_d  = full_rise_q;
                        state_d  = FALL;
                        load     = 1'b1;
                        load_pos = rebase;
                        offset_d = rebase;
                    end
                end
                FALL: begin
                    if (turn_c) begin
                        if (pk_ok_q) begin
                            meas_valid_d = 1'b1;
                            peak_d       = pk_q;
                            trough_d     = ext;
                            rise_len_d   = rl_q;
                            fall_len_d   = ext_pos;
                            period_d     = PER_W'(rl_q) + PER_W'(ext_pos);
                            timeout_d    = 1'b0;
                        end
                        state_d     = RISE;
                        full_rise_d = 1'b1;
                        load        = 1'b1;
                        load_pos    = rebase;
                        offset_d    = rebase;
                    end
                end
                default: state_d = ACQ;
            endcase

            // A turn on the saturating sample rebases the offset instead of timing out
            if (sat && !turn_c) begin
                timeout_d   = 1'b1;
                state_d     = ACQ;
                full_rise_d = 1'b0;
                pk_ok_d     = 1'b0;
                load        = 1'b1;
                load_pos    = '0;
                offset_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACQ;
            offset_q    <= '0;
            seeded_q    <= 1'b0;
            full_rise_q <= 1'b0;
            pk_ok_q     <= 1'b0;
            pk_q        <= '0;
            rl_q        <= '0;
            meas_valid  <= 1'b0;
            peak        <= '0;
            trough      <= '0;
            rise_len    <= '0;
            fall_len    <= '0;
            period      <= '0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            seeded_q    <= seeded_d;
            full_rise_q <= full_rise_d;
            pk_ok_q     <= pk_ok_d;
            pk_q        <= pk_d;
            rl_q        <= rl_d;
            meas_valid  <= meas_valid_d;
            peak        <= peak_d;
            trough      <= trough_d;
            rise_len    <= rise_len_d;
            fall_len    <= fall_len_d;
            period      <= period_d;
            timeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_triangle_meas.sv
// Directed bench for triangle_meas: table of ideal waveforms plus jitter,
// timeout and mid-fall reset sequences.
module tb_triangle_meas;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = 8'd0;

    logic        meas_valid, timeout;
    logic [7:0]  peak, trough;
    logic [23:0] rise_len, fall_len;
    logic [24:0] period;

    logic       mv8, to8;
    logic [7:0] pk8, tr8, rl8, fl8;
    logic [8:0] per8;

    always #5 clk = ~clk;

    triangle_meas u_dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .meas_valid(meas_valid), .peak(peak), .trough(trough),
        .rise_len(rise_len), .fall_len(fall_len), .period(period), .timeout(timeout)
    );

    triangle_meas #(.DT_W(8), .CNT_W(8), .HYST(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .meas_valid(mv8), .peak(pk8), .trough(tr8),
        .rise_len(rl8), .fall_len(fl8), .period(per8), .timeout(to8)
    );

    typedef struct {
        longint pk, tr, rl, fl, per;
    } res_t;

    typedef struct {
        int lo, hi, up, dn, np;
        bit gaps;
        longint pk, tr, rl, fl, per;
        int nres;
    } vec_t;

    res_t   res_q[$];
    logic   to8_q[$];
    res_t   r8_q[$];

    // Result capture, one entry per meas_valid cycle
    always @(negedge clk) begin
        if (meas_valid)
            res_q.push_back('{longint'(peak), longint'(trough), longint'(rise_len),
                              longint'(fall_len), longint'(period)});
        if (mv8) begin
            to8_q.push_back(to8);
            r8_q.push_back('{longint'(pk8), longint'(tr8), longint'(rl8),
                             longint'(fl8), longint'(per8)});
        end
    end

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  gap_mode = 1'b0;
    bit  jit_mode = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic send(input int v);
        int x;
        x = v;
        if (jit_mode) x = v + int'($urandom_range(4)) - 2;
        if (x < 0) x = 0;
        if (x > 255) x = 255;
        @(negedge clk);
        sample       = 8'(x);
        sample_valid = 1'b1;
        if (gap_mode) begin
            repeat (2) begin
                @(negedge clk);
                sample_valid = 1'b0;
                sample       = 8'($urandom);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tri_periods(input int lo, input int hi, input int up, input int dn, input int np);
        for (int p = 0; p < np; p++) begin
            for (int v = lo; v < hi; v += up) send(v);
            for (int v = hi; v > lo; v -= dn) send(v);
        end
    endtask

    task automatic tail(input int lo, input int up);
        for (int k = 0; k < 8; k++) send(lo + k * up);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " meas_valid"}, longint'(meas_valid), 0);
        chk({tag, " peak"},       longint'(peak), 0);
        chk({tag, " trough"},     longint'(trough), 0);
        chk({tag, " rise_len"},   longint'(rise_len), 0);
        chk({tag, " fall_len"},   longint'(fall_len), 0);
        chk({tag, " period"},     longint'(period), 0);
        chk({tag, " timeout"},    longint'(timeout), 0);
    endtask

    vec_t vecs[5];

    initial begin
        int rb, r8b;

        vecs[0] = '{0, 200, 1, 1, 3, 1'b0, 200, 0, 200, 200, 400, 2};
        vecs[1] = '{0, 200, 1, 1, 3, 1'b1, 200, 0, 200, 200, 400, 2};
        vecs[2] = '{0, 100, 2, 1, 3, 1'b0, 100, 0,  50, 100, 150, 2};
        vecs[3] = '{10, 60, 1, 1, 4, 1'b0,  60, 10, 50,  50, 100, 3};
        vecs[4] = '{0, 200, 1, 4, 3, 1'b0, 200, 0, 200,  50, 250, 2};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_zero("reset");
        chk("reset timeout8", longint'(to8), 0);

        // Table-driven ideal waveforms
        foreach (vecs[i]) begin
            do_reset();
            rb       = res_q.size();
            gap_mode = vecs[i].gaps;
            tri_periods(vecs[i].lo, vecs[i].hi, vecs[i].up, vecs[i].dn, vecs[i].np);
            tail(vecs[i].lo, vecs[i].up);
            gap_mode = 1'b0;
            idle(4);
            chk($sformatf("v%0d count", i), longint'(res_q.size() - rb), longint'(vecs[i].nres));
            for (int k = rb; k < res_q.size(); k++) begin
                chk($sformatf("v%0d r%0d peak", i, k - rb),     res_q[k].pk,  vecs[i].pk);
                chk($sformatf("v%0d r%0d trough", i, k - rb),   res_q[k].tr,  vecs[i].tr);
                chk($sformatf("v%0d r%0d rise_len", i, k - rb), res_q[k].rl,  vecs[i].rl);
                chk($sformatf("v%0d r%0d fall_len", i, k - rb), res_q[k].fl,  vecs[i].fl);
                chk($sformatf("v%0d r%0d period", i, k - rb),   res_q[k].per, vecs[i].per);
            end
            chk($sformatf("v%0d hold peak", i),   longint'(peak), vecs[i].pk);
            chk($sformatf("v%0d hold period", i), longint'(period), vecs[i].per);
            chk($sformatf("v%0d pulse low", i),   longint'(meas_valid), 0);
        end

        // Jittered ideal triangle
        do_reset();
        rb       = res_q.size();
        jit_mode = 1'b1;
        tri_periods(0, 200, 1, 1, 3);
        tail(0, 1);
        jit_mode = 1'b0;
        idle(4);
        chk("jitter count", longint'(res_q.size() - rb), 2);
        for (int k = rb; k < res_q.size(); k++) begin
            chk_rng("jitter peak",   res_q[k].pk,  198, 202);
            chk_rng("jitter trough", res_q[k].tr,  0, 2);
            chk_rng("jitter period", res_q[k].per, 396, 404);
        end

        // DC input saturates the 8-bit counter, then a triangle clears timeout
        do_reset();
        rb  = res_q.size();
        r8b = r8_q.size();
        repeat (254) send(128);
        idle(1);
        chk("dc 254 timeout8", longint'(to8), 0);
        send(128);
        idle(1);
        chk("dc 255 timeout8", longint'(to8), 1);
        chk("dc timeout24", longint'(timeout), 0);
        chk("dc no result8", longint'(r8_q.size() - r8b), 0);
        tri_periods(0, 200, 1, 1, 1);
        idle(1);
        chk("dc held timeout8", longint'(to8), 1);
        tri_periods(0, 200, 1, 1, 2);
        tail(0, 1);
        idle(4);
        chk("dc count8", longint'(r8_q.size() - r8b), 2);
        if (r8_q.size() > r8b) begin
            chk("dc first timeout8", longint'(to8_q[r8b]), 0);
            chk("dc peak8",   r8_q[r8b].pk, 200);
            chk("dc rl8",     r8_q[r8b].rl, 200);
            chk("dc period8", r8_q[r8b].per, 400);
        end
        chk("dc final timeout8", longint'(to8), 0);
        chk("dc count24", longint'(res_q.size() - rb), 2);

        // Reset in the middle of a fall discards everything
        do_reset();
        rb = res_q.size();
        tri_periods(0, 200, 1, 1, 2);
        for (int v = 0; v < 200; v++) send(v);
        for (int v = 200; v > 100; v--) send(v);
        idle(1);
        chk("midrst pre count", longint'(res_q.size() - rb), 1);
        chk("midrst pre peak", longint'(peak), 200);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_zero("midrst");
        rb = res_q.size();
        for (int v = 100; v > 0; v--) send(v);
        tri_periods(0, 200, 1, 1, 2);
        tail(0, 1);
        idle(4);
        chk("midrst post count", longint'(res_q.size() - rb), 1);
        if (res_q.size() > rb) begin
            chk("midrst rise_len", res_q[rb].rl, 200);
            chk("midrst period",   res_q[rb].per, 400);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/triangle_meas.md
# triangle_meas

Measurement block for the AI-match waveform path: consumes the 8-bit unsigned sample stream of a triangle-type signal (ADC capture or triangle DDS output) and extracts peak, trough, rise length, fall length and period, in samples. Slope tracking uses a hysteresis threshold so that small jitter does not register as a turning point. One registered result is emitted per completed rise+fall cycle. The result feeds the classifier/parameter-match logic.

## Interface
- `DT_W`, 8, sample width, unsigned.
- `CNT_W`, 24, segment length counter width.
- `HYST`, 4, minimum retreat from a running extremum that declares a turning point.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `sample_valid` in 1: qualifies `sample`.
- `sample` in DT_W: unsigned sample.
- `meas_valid` out 1: one-cycle result pulse.
- `peak` out DT_W: maximum of the measured rise.
- `trough` out DT_W: minimum ending the measured fall.
- `rise_len` out CNT_W: samples from the previous trough to `peak`.
- `fall_len` out CNT_W: samples from `peak` to `trough`.
- `period` out CNT_W+1: `rise_len` + `fall_len`, no truncation.
- `timeout` out 1: level; segment counter saturated.

## Operation
- States: ACQ, RISE, FALL. Reset enters ACQ.
- Only cycles with `sample_valid`=1 act. All lengths count accepted samples, never clocks.
- `offset`: index of the current sample relative to the last extremum (extremum = 0). It increments per accepted sample.
- `ext_pos`: offset of the running extremum.
- ACQ:
  - The first sample loads run_max = run_min = sample.
  - Later samples update run_min.
  - When sample − run_min ≥ HYST: go to RISE with run_max = sample, offset = 0, ext_pos = 0, `full_rise` = 0.
- RISE:
  - sample > run_max (strict) sets run_max = sample and ext_pos = offset. A plateau keeps the first occurrence.
  - When run_max − sample ≥ HYST: the peak is declared.
    - Latch pk = run_max and rl = ext_pos.
    - `pk_ok` = `full_rise`.
    - Enter FALL with run_min = sample, offset = offset − ext_pos, ext_pos = that offset.
- FALL: mirror of RISE.
  - sample < run_min (strict) sets run_min = sample and ext_pos = offset.
  - When sample − run_min ≥ HYST: the trough is declared.
    - If `pk_ok`, emit a result: peak = pk, trough = run_min, rise_len = rl, fall_len = ext_pos, period = rl + ext_pos.
    - Enter RISE with `full_rise` = 1 and the offset rebased as above.
- Consequence: the first peak after ACQ never produces a result. The first `meas_valid` follows the second trough detection.
- All hysteresis comparisons are done in DT_W+1 bits; no wrap-around.
- Timeout:
  - If offset reaches 2^CNT_W−1 in any state: set `timeout` = 1, go to ACQ, clear `full_rise` and `pk_ok`.
  - The sample that saturates the counter re-seeds ACQ.
  - `timeout` clears on the next `meas_valid`.
- A turn condition and a new extremum cannot coincide. A timeout and a turn on the same sample: the turn wins and the offset rebases.

## Timing
- Reset values: `meas_valid`, `peak`, `trough`, `rise_len`, `fall_len`, `period` and `timeout` are all 0. Internal registers are cleared and the state is ACQ.
- Latency: `meas_valid` and the result fields update on the clock edge after the sample that detects the trough. Fields hold until the next result.
- `meas_valid` is high for exactly one cycle. Back-to-back results are impossible (minimum 2 samples apart).
- Reset mid-cycle discards the partial measurement. The next cycle restarts from ACQ.
- `sample_valid` gaps freeze all state. Results are identical to gap-free input.

## Structure
- A shared package/header holds:
  - the state encodings (ACQ/RISE/FALL);
  - the default DT_W, CNT_W and HYST values;
  - the width of `period` (CNT_W+1).
- One natural sub-module: `extremum_tracker`. It holds the running max/min, the ext_pos capture and the hysteresis compare, is parameterised for max/min polarity, and is instantiated once with muxed polarity.
- The state machine, offset counter and result registers live in `triangle_meas`.

## Test plan
- Ideal triangle, step +1/−1 per sample between 0 and 200, HYST=4, run for 3 cycles → `meas_valid` after the second trough. Values: peak=200, trough=0, rise_len=200, fall_len=200, period=400. Repeats every 400 samples.
- Same triangle with ±2 random jitter → no extra turning points. Peak within 198..202, period within 400±4.
- Asymmetric wave: rise 0→100 in 50 samples (step 2), fall 100→0 in 100 samples (step 1) → rise_len=50, fall_len=100, period=150.
- DC input at 128 with CNT_W=8 → `timeout`=1 after 255 accepted samples and no `meas_valid`. Then apply the ideal triangle → `timeout` clears with the first result.
- Ideal triangle with `sample_valid` toggling 1-0-0 → identical results to the first test.
- `rst_n` low for 1 cycle mid-fall → all outputs 0 the next cycle. The first subsequent `meas_valid` occurs only after two trough detections.
